// File: rtl/axi_bram_master.sv
// axi_bram_master: single-word BRAM-style requests issued as single-beat AXI4.
// Optional watchdog enabled by defining AXI_BRAM_MASTER_TIMEOUT_EN.
module axi_bram_master #(
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned MEM_ADDR_WIDTH = 19,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [AXI_ID_WIDTH-1:0]   AXI_ID    = '0
`ifdef AXI_BRAM_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata_i,
  output logic                        rsp_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        timeout_o,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arlock,
  output logic [3:0]                  m_axi_arcache,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int unsigned SW  = AXI_DATA_WIDTH / 8;
  localparam int unsigned LSB = $clog2(SW);

  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RDATA
  } state_t;

  state_t state_q, state_d;

  logic aw_valid_q, aw_valid_d;
  logic w_valid_q, w_valid_d;
  logic b_ready_q, b_ready_d;
  logic ar_valid_q, ar_valid_d;
  logic r_ready_q, r_ready_d;
  logic req_ready_q, req_ready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_err_q, rsp_err_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]             strb_q, strb_d;

  logic accept;
  logic aw_done;
  logic w_done;
  logic [AXI_ADDR_WIDTH-1:0] req_addr_full;

  assign accept  = req_valid_i & req_ready_q;
  assign aw_done = ~aw_valid_q | m_axi_awready;
  assign w_done  = ~w_valid_q | m_axi_wready;

  assign req_addr_full =
    (BASE_ADDR + AXI_ADDR_WIDTH'(req_addr_i)) &
    ~AXI_ADDR_WIDTH'(SW - 1);

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    addr_d      = addr_q;
    data_d      = data_q;
    strb_d      = strb_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr_full;
          data_d = req_wdata_i;
          strb_d = req_we_i;
          if (|req_we_i) begin
            state_d    = WADDR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = RADDR;
            ar_valid_d = 1'b1;
          end
        end
      end
      WADDR: begin
        aw_valid_d = aw_valid_q & ~m_axi_awready;
        w_valid_d  = w_valid_q & ~m_axi_wready;
        if (aw_done && w_done) begin
          state_d   = WRESP;
          b_ready_d = 1'b1;
        end
      end
      WRESP: begin
        if (m_axi_bvalid) begin
          state_d     = IDLE;
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = m_axi_bresp[1];
        end
      end
      RADDR: begin
        if (m_axi_arready) begin
          state_d    = RDATA;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      RDATA: begin
        if (m_axi_rvalid) begin
          state_d     = IDLE;
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = m_axi_rresp[1];
          rsp_rdata_d = m_axi_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      strb_q      <= '0;
    end else begin
      state_q     <= state_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
    end
  end

`ifdef AXI_BRAM_MASTER_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        timeout_q;

  // Watchdog: counts busy cycles, flag sticks until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
    end else if (state_q != IDLE &&
                 tmo_cnt_q != 32'(TIMEOUT_CYCLES)) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
      if (tmo_cnt_q + 32'd1 == 32'(TIMEOUT_CYCLES))
        timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  logic unused_in;
  assign unused_in = ^{m_axi_bid, m_axi_rid, m_axi_rlast,
                       m_axi_bresp[0], m_axi_rresp[0]};

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(LSB);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0010;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = aw_valid_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_wstrb   = strb_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = w_valid_q;
  assign m_axi_bready  = b_ready_q;
  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(LSB);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = ar_valid_q;
  assign m_axi_rready  = r_ready_q;

endmodule

// File: tb/tb_axi_bram_master.sv
// tb_axi_bram_master: directed bench with AXI RAM slave,
// request-level reference model and scoreboard.
module tb_axi_bram_master;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam logic [9:0]  AID  = 10'h2A;
  localparam int          TMO  = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [7:0]  req_we_i = '0;
  logic [18:0] req_addr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        timeout_o;

  logic [9:0]  m_axi_awid;
  logic [63:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [9:0]  m_axi_bid = 10'h3FF;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [9:0]  m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [9:0]  m_axi_rid = 10'h3FF;
  logic [63:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  axi_bram_master #(
    .AXI_ID_WIDTH  (10),
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .MEM_ADDR_WIDTH(19),
    .BASE_ADDR     (BASE),
    .AXI_ID        (AID)
`ifdef AXI_BRAM_MASTER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .timeout_o(timeout_o),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old,
                                        logic [63:0] nw,
                                        logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++)
      if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] axi_addr(logic [18:0] a);
    return (BASE + {45'd0, a}) & ~64'h7;
  endfunction

  // Slave knobs, set by the stimulus before each request.
  int aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00;
  logic [1:0] rresp_cfg = 2'b00;

  typedef struct {
    bit          rd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    bit          err;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] slv_mem [logic [63:0]];
  logic [63:0] last_rd = '0;
  logic [63:0] last_awaddr = '0;

  int up = 0;
  always @(posedge clk or negedge rst_ni)
    if (!rst_ni) up = 0;
    else if (up < 10) up = up + 1;

  // AXI RAM slave with per-channel ready/valid delays.
  bit aw_got = 0, w_got = 0, ar_got = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic [63:0] aw_a, w_d, ar_a;
  logic [7:0]  w_s;
  bit p_aw = 0, p_w = 0, p_ar = 0;
  logic [63:0] p_awaddr, p_araddr;

  always @(negedge clk) begin
    if (!rst_ni) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0;  m_axi_rvalid = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
      p_aw = 0; p_w = 0; p_ar = 0;
    end else begin
      if (p_aw && !m_axi_awready) begin
        chk("aw_hold", m_axi_awvalid, 1);
        chk("aw_addr_hold", m_axi_awaddr, p_awaddr);
      end
      if (p_w && !m_axi_wready) chk("w_hold", m_axi_wvalid, 1);
      if (p_ar && !m_axi_arready) begin
        chk("ar_hold", m_axi_arvalid, 1);
        chk("ar_addr_hold", m_axi_araddr, p_araddr);
      end
      if (aw_got) chk("aw_dup", m_axi_awvalid, 0);
      if (w_got) chk("w_dup", m_axi_wvalid, 0);
      if (ar_got) chk("ar_dup", m_axi_arvalid, 0);

      m_axi_bvalid = 0;
      if (aw_got && w_got) begin
        if (b_cnt >= b_dly) begin
          m_axi_bvalid = 1;
          m_axi_bresp = bresp_cfg;
          if (m_axi_bready) begin
            slv_mem[aw_a] = merge(slv_mem.exists(aw_a) ?
                                  slv_mem[aw_a] : 64'd0, w_d, w_s);
            aw_got = 0; w_got = 0; b_cnt = 0;
          end
        end else b_cnt++;
      end

      m_axi_rvalid = 0;
      m_axi_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      if (ar_got) begin
        if (r_cnt >= r_dly) begin
          m_axi_rvalid = 1;
          m_axi_rdata = slv_mem.exists(ar_a) ? slv_mem[ar_a] : 64'd0;
          m_axi_rresp = rresp_cfg;
          m_axi_rlast = 1;
          if (m_axi_rready) begin ar_got = 0; r_cnt = 0; end
        end else r_cnt++;
      end

      m_axi_awready = 0;
      if (m_axi_awvalid && !aw_got) begin
        if (aw_cnt >= aw_dly) begin
          m_axi_awready = 1; aw_got = 1; aw_cnt = 0;
          aw_a = m_axi_awaddr; last_awaddr = m_axi_awaddr;
          chk("aw_attr", {m_axi_awid, m_axi_awlen, m_axi_awsize,
              m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot},
              {AID, 8'd0, 3'd3, 2'b01, 1'b0, 4'b0010, 3'b000});
          if (q.size() == 0) chk("aw_no_model", 1, 0);
          else chk("awaddr", m_axi_awaddr, q[0].addr);
        end else aw_cnt++;
      end

      m_axi_wready = 0;
      if (m_axi_wvalid && !w_got) begin
        if (w_cnt >= w_dly) begin
          m_axi_wready = 1; w_got = 1; w_cnt = 0;
          w_d = m_axi_wdata; w_s = m_axi_wstrb;
          chk("wlast", m_axi_wlast, 1);
          if (q.size() == 0) chk("w_no_model", 1, 0);
          else begin
            chk("wdata", m_axi_wdata, q[0].data);
            chk("wstrb", m_axi_wstrb, q[0].strb);
          end
        end else w_cnt++;
      end

      m_axi_arready = 0;
      if (m_axi_arvalid && !ar_got) begin
        if (aw_cnt >= 0 && r_cnt >= 0) begin
          m_axi_arready = 1; ar_got = 1; ar_a = m_axi_araddr;
          chk("ar_attr", {m_axi_arid, m_axi_arlen, m_axi_arsize,
              m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot},
              {AID, 8'd0, 3'd3, 2'b01, 1'b0, 4'b0010, 3'b000});
          if (q.size() == 0) chk("ar_no_model", 1, 0);
          else chk("araddr", m_axi_araddr, q[0].addr);
        end
      end

      p_aw = m_axi_awvalid; p_awaddr = m_axi_awaddr;
      p_w  = m_axi_wvalid;
      p_ar = m_axi_arvalid; p_araddr = m_axi_araddr;
    end
  end

  // Scoreboard: request-level model vs DUT responses every cycle.
  always @(negedge clk) begin
    if (!rst_ni) begin
      q.delete();
      last_rd = '0;
    end else begin
      if (rsp_valid_o) begin
        if (q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("rsp_err", rsp_err_o, e.err);
          if (e.rd) begin
            chk("rsp_rdata", rsp_rdata_o, e.data);
            last_rd = e.data;
          end else chk("rsp_rdata_hold", rsp_rdata_o, last_rd);
        end
      end
      chk("req_ready", req_ready_o, (q.size() == 0 && up >= 1));
      chk("timeout_idle", timeout_o & (q.size() == 0), 0);
      if (req_valid_i && req_ready_o) begin
        e.rd = (req_we_i == 8'd0);
        e.addr = axi_addr(req_addr_i);
        e.strb = req_we_i;
        if (e.rd) begin
          e.data = ref_mem.exists(e.addr) ? ref_mem[e.addr] : 64'd0;
          e.err = rresp_cfg[1];
        end else begin
          e.data = req_wdata_i;
          e.err = bresp_cfg[1];
          ref_mem[e.addr] = merge(ref_mem.exists(e.addr) ?
                                  ref_mem[e.addr] : 64'd0,
                                  req_wdata_i, req_we_i);
        end
        q.push_back(e);
      end
    end
  end

  task automatic do_req(input logic [7:0] we, input logic [18:0] a,
                        input logic [63:0] d, input bit wait_rsp,
                        output int lat);
    bit acc;
    acc = 0;
    lat = -1;
    @(posedge clk); #1;
    req_valid_i = 1; req_we_i = we; req_addr_i = a; req_wdata_i = d;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk); #1;
      if (req_ready_o) acc = 1;
    end
    if (!acc) begin
      chk("req_accept_timeout", 0, 1);
      req_valid_i = 0;
      return;
    end
    @(posedge clk); #1;
    req_valid_i = 0;
    if (wait_rsp) begin
      for (int k = 1; k <= 3000 && lat < 0; k++) begin
        @(negedge clk); #1;
        if (rsp_valid_o) lat = k;
      end
      if (lat < 0) chk("rsp_wait_timeout", 0, 1);
    end
  endtask

  int lat;
  bit seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
        m_axi_bready, m_axi_rready, req_ready_o, rsp_valid_o}, 0);
    chk("rst_rsp", {rsp_rdata_o, rsp_err_o, timeout_o}, 0);
    @(negedge clk); #1;
    rst_ni = 1;

    do_req(8'hFF, 19'h10, 64'hDEADBEEF_CAFEF00D, 1, lat);
    chk("t1_latency", lat, 3);
    chk("t1_awaddr", last_awaddr, 64'h8000_0010);
    chk("t1_err", rsp_err_o, 0);

    do_req(8'h00, 19'h10, 64'd0, 1, lat);
    chk("t2_latency", lat, 3);
    chk("t2_rdata", rsp_rdata_o, 64'hDEADBEEF_CAFEF00D);

    aw_dly = 5;
    do_req(8'h0F, 19'h13, 64'h11223344_55667788, 1, lat);
    chk("t3_latency", lat, 8);
    aw_dly = 0; w_dly = 3; b_dly = 1;
    do_req(8'hF0, 19'h18, 64'hA5A5A5A5_00000000, 1, lat);
    chk("t3b_latency", lat, 7);
    w_dly = 0; b_dly = 0; r_dly = 2;
    do_req(8'h00, 19'h10, 64'd0, 1, lat);
    chk("t3_rdata", rsp_rdata_o, 64'hDEADBEEF_55667788);
    chk("t3r_latency", lat, 5);
    r_dly = 0;
    do_req(8'h00, 19'h18, 64'd0, 1, lat);
    chk("t3_rdata2", rsp_rdata_o, 64'hA5A5A5A5_00000000);

    bresp_cfg = 2'b10;
    do_req(8'hFF, 19'h40, 64'h0123_4567_89AB_CDEF, 1, lat);
    chk("t4_berr", rsp_err_o, 1);
    bresp_cfg = 2'b00; rresp_cfg = 2'b11;
    do_req(8'h00, 19'h40, 64'd0, 1, lat);
    chk("t4_rerr", rsp_err_o, 1);
    rresp_cfg = 2'b01;
    do_req(8'h00, 19'h40, 64'd0, 1, lat);
    chk("t4_exokay", rsp_err_o, 0);
    rresp_cfg = 2'b00;

    r_dly = 100000;
    do_req(8'h00, 19'h10, 64'd0, 0, lat);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk); #1;
      if (m_axi_rready) seen = 1;
    end
    chk("t5_in_rdata", seen, 1);
    #1 rst_ni = 0;
    #1;
    chk("t5_abort", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
        m_axi_bready, m_axi_rready, req_ready_o, rsp_valid_o}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    r_dly = 0;
    rst_ni = 1;
    do_req(8'h00, 19'h10, 64'd0, 1, lat);
    chk("t5_latency", lat, 3);
    chk("t5_rdata", rsp_rdata_o, 64'hDEADBEEF_55667788);

`ifdef AXI_BRAM_MASTER_TIMEOUT_EN
    b_dly = 100000;
    do_req(8'hFF, 19'h20, 64'h1, 0, lat);
    repeat (TMO - 5) @(negedge clk);
    #1;
    chk("t6_no_timeout_yet", timeout_o, 0);
    repeat (10) @(negedge clk);
    #1;
    chk("t6_timeout", timeout_o, 1);
    chk("t6_bready", m_axi_bready, 1);
    rst_ni = 0;
    #1;
    chk("t6_timeout_clr", timeout_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    b_dly = 0;
    rst_ni = 1;
    do_req(8'h00, 19'h10, 64'd0, 1, lat);
    chk("t6_recover", lat, 3);
`endif

    repeat (4) @(negedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
